// File: rtl/rom_readback.sv
// rom_readback: serves HPS upload reads by reading back the ROM regions of the
// download address map through the shared dpram read-back port, keeping a
// per-session checksum and byte count.
module rom_readback #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        UPLOAD,
    input  logic        RD,
    input  logic [24:0] ADDR,
    output logic [7:0]  DOUT,
    output logic        WAIT,
    output logic [3:0]  MEM_SEL,
    output logic [16:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [7:0]  MEM_Q,
    output logic [15:0] CHKSUM,
    output logic [24:0] BYTE_CNT,
    output logic        DONE
);

    localparam int unsigned AW = 25;
    localparam int unsigned OW = 17;
    localparam int unsigned CW = 16;
    localparam int unsigned LW = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LAT  = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;

    localparam logic [3:0] SEL_NONE = 4'hF;

    logic [1:0]    state, state_d;
    logic [LW-1:0] cnt, cnt_d;
    logic          upload_q;

    logic [7:0]    dout_d;
    logic          wait_d;
    logic [3:0]    sel_d;
    logic [OW-1:0] addr_d;
    logic          rd_d;
    logic [CW-1:0] chk_d;
    logic [AW-1:0] bcnt_d;
    logic          done_d;

    logic [3:0]    dec_sel;
    logic [OW-1:0] dec_off;
    logic [16:0]   spr_off;
    logic [9:0]    prom_off;
    logic [7:0]    cap_byte;
    logic          rise, fall;

    assign spr_off  = 17'(ADDR - 25'h38000);
    assign prom_off = 10'(ADDR - 25'h58000);
    assign cap_byte = (MEM_SEL == SEL_NONE) ? 8'hFF : MEM_Q;
    assign rise     = UPLOAD & ~upload_q;
    assign fall     = ~UPLOAD & upload_q;

    // Address map decode: byte address -> region index and offset
    always_comb begin
        dec_sel = SEL_NONE;
        dec_off = '0;
        if (ADDR < 25'h04000) begin
            dec_sel = 4'd0;
            dec_off = OW'(ADDR);
        end else if (ADDR < 25'h08000) begin
            dec_sel = 4'd1;
            dec_off = OW'(ADDR - 25'h04000);
        end else if (ADDR < 25'h10000) begin
            dec_sel = 4'd2;
            dec_off = OW'(ADDR - 25'h08000);
        end else if (ADDR < 25'h12000) begin
            dec_sel = 4'd3;
            dec_off = OW'(ADDR - 25'h10000);
        end else if (ADDR < 25'h14000) begin
            dec_sel = 4'd4;
            dec_off = OW'(ADDR - 25'h12000);
        end else if (ADDR < 25'h16000) begin
            dec_sel = 4'd5;
            dec_off = OW'(ADDR - 25'h14000);
        end else if (ADDR < 25'h18000) begin
            dec_sel = 4'd6;
            dec_off = OW'(ADDR - 25'h16000);
        end else if (ADDR < 25'h38000) begin
            dec_sel = 4'd7;
            dec_off = OW'(ADDR - 25'h18000);
        end else if (ADDR < 25'h58000) begin
            dec_sel = 4'd8 + 4'(spr_off[16:15]);
            dec_off = OW'(spr_off[14:0]);
        end else if (ADDR < 25'h58300) begin
            dec_sel = 4'd12 + 4'(prom_off[9:8]);
            dec_off = OW'(prom_off[7:0]);
        end
    end

    // Next-state and next-output logic; an UPLOAD fall aborts any read in flight
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dout_d  = DOUT;
        wait_d  = WAIT;
        sel_d   = MEM_SEL;
        addr_d  = MEM_ADDR;
        rd_d    = 1'b0;
        chk_d   = CHKSUM;
        bcnt_d  = BYTE_CNT;
        done_d  = 1'b0;
        if (fall) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            wait_d  = 1'b0;
            sel_d   = SEL_NONE;
        end else begin
            if (rise) begin
                chk_d  = '0;
                bcnt_d = '0;
            end
            case (state)
                S_IDLE: begin
                    if (RD && UPLOAD) begin
                        sel_d  = dec_sel;
                        addr_d = dec_off;
                        wait_d = 1'b1;
                        if (dec_sel == SEL_NONE) begin
                            state_d = S_CAPT;
                        end else begin
                            rd_d    = 1'b1;
                            cnt_d   = LW'(RD_LATENCY - 1);
                            state_d = S_LAT;
                        end
                    end
                end
                S_LAT: begin
                    if (cnt == '0) begin
                        state_d = S_CAPT;
                    end else begin
                        cnt_d = cnt - LW'(1);
                    end
                end
                S_CAPT: begin
                    dout_d  = cap_byte;
                    chk_d   = CHKSUM + CW'(cap_byte);
                    bcnt_d  = (&BYTE_CNT) ? BYTE_CNT : BYTE_CNT + AW'(1);
                    wait_d  = 1'b0;
                    sel_d   = SEL_NONE;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            cnt      <= '0;
            upload_q <= 1'b0;
            DOUT     <= 8'h00;
            WAIT     <= 1'b0;
            MEM_SEL  <= SEL_NONE;
            MEM_ADDR <= '0;
            MEM_RD   <= 1'b0;
            CHKSUM   <= '0;
            BYTE_CNT <= '0;
            DONE     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            upload_q <= UPLOAD;
            DOUT     <= dout_d;
            WAIT     <= wait_d;
            MEM_SEL  <= sel_d;
            MEM_ADDR <= addr_d;
            MEM_RD   <= rd_d;
            CHKSUM   <= chk_d;
            BYTE_CNT <= bcnt_d;
            DONE     <= done_d;
        end
    end

endmodule

// File: tb/tb_rom_readback.sv
// Testbench for rom_readback: randomized reads against a region-table model,
// with a queue scoreboard checked by an independent capture monitor.
module tb_rom_readback;

    localparam int unsigned L = 2;

    localparam int BASE [15] = '{32'h00000, 32'h04000, 32'h08000, 32'h10000, 32'h12000,
                                 32'h14000, 32'h16000, 32'h18000, 32'h38000, 32'h40000,
                                 32'h48000, 32'h50000, 32'h58000, 32'h58100, 32'h58200};
    localparam int SIZE [15] = '{16384, 16384, 32768, 8192, 8192, 8192, 8192, 131072,
                                 32768, 32768, 32768, 32768, 256, 256, 256};

    localparam int BND_A   [5] = '{32'h11FFF, 32'h12000, 32'h37FFF, 32'h580FF, 32'h58300};
    localparam int BND_SEL [5] = '{3, 4, 7, 12, 15};
    localparam int BND_OFF [5] = '{32'h1FFF, 0, 32'h1FFFF, 32'hFF, 0};

    logic        CLK = 1'b0;
    logic        RESET_N, UPLOAD, RD;
    logic [24:0] ADDR;
    logic [7:0]  DOUT, MEM_Q;
    logic        WAIT, MEM_RD, DONE;
    logic [3:0]  MEM_SEL;
    logic [16:0] MEM_ADDR;
    logic [15:0] CHKSUM;
    logic [24:0] BYTE_CNT;

    rom_readback #(.RD_LATENCY(L)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .UPLOAD(UPLOAD), .RD(RD), .ADDR(ADDR),
        .DOUT(DOUT), .WAIT(WAIT), .MEM_SEL(MEM_SEL), .MEM_ADDR(MEM_ADDR),
        .MEM_RD(MEM_RD), .MEM_Q(MEM_Q), .CHKSUM(CHKSUM), .BYTE_CNT(BYTE_CNT),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  dout;
        logic [15:0] chk;
        logic [24:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          rd_pulses = 0;
    logic        prev_wait = 1'b0;
    logic [15:0] m_chk;
    logic [24:0] m_cnt;
    int          q_mode;
    logic [7:0]  q_fix;
    logic [7:0]  pipe [L];
    logic [3:0]  last_sel;
    logic [16:0] last_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Contents of the ROM regions; colour PROMs are 4 bits wide, zero-extended
    function automatic logic [7:0] mem_val(input logic [3:0] s, input logic [16:0] o);
        logic [7:0] v;
        v = 8'(32'(s) * 37 + 32'(o) * 13 + 32'(o >> 8));
        if (s >= 4'd12) v = {4'h0, v[3:0]};
        return v;
    endfunction

    function automatic void ref_decode(input logic [24:0] a, output int sel, output int off);
        sel = 15;
        off = 0;
        for (int i = 0; i < 15; i++) begin
            if (int'(a) >= BASE[i] && int'(a) < BASE[i] + SIZE[i]) begin
                sel = i;
                off = int'(a) - BASE[i];
            end
        end
    endfunction

    // Read-back RAM: data appears L cycles after MEM_SEL/MEM_ADDR are presented
    always @(posedge CLK) begin
        pipe[0] <= mem_val(MEM_SEL, MEM_ADDR);
        for (int k = 1; k < int'(L); k++) pipe[k] <= pipe[k-1];
        cyc <= cyc + 1;
    end
    assign MEM_Q = (q_mode == 1) ? q_fix : pipe[L-1];

    always @(negedge CLK) if (MEM_RD === 1'b1) rd_pulses++;

    // Monitor: every completed read (WAIT falls without DONE) is checked against the queue
    always @(negedge CLK) begin
        if (RESET_N && prev_wait && !WAIT && !DONE) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_capture: got DOUT 0x%0h, required no capture", DOUT);
            end else begin
                mon_e = sb.pop_front();
                check("cap_dout", 32'(DOUT), 32'(mon_e.dout));
                check("cap_chksum", 32'(CHKSUM), 32'(mon_e.chk));
                check("cap_byte_cnt", 32'(BYTE_CNT), 32'(mon_e.cnt));
                check("cap_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        prev_wait = RESET_N ? WAIT : 1'b0;
    end

    task automatic check_reset(input string tag);
        check({tag, "_dout"}, 32'(DOUT), 32'h00);
        check({tag, "_wait"}, 32'(WAIT), 32'h0);
        check({tag, "_mem_sel"}, 32'(MEM_SEL), 32'hF);
        check({tag, "_mem_addr"}, 32'(MEM_ADDR), 32'h0);
        check({tag, "_mem_rd"}, 32'(MEM_RD), 32'h0);
        check({tag, "_chksum"}, 32'(CHKSUM), 32'h0);
        check({tag, "_byte_cnt"}, 32'(BYTE_CNT), 32'h0);
        check({tag, "_done"}, 32'(DONE), 32'h0);
    endtask

    task automatic do_read(input logic [24:0] a, input bit dup);
        int         sel, off, c0, p0;
        logic [7:0] d;
        bit         mapped;
        exp_t       e;
        ref_decode(a, sel, off);
        mapped = (sel != 15);
        if (!mapped) d = 8'hFF;
        else if (q_mode == 1) d = q_fix;
        else d = mem_val(4'(sel), 17'(off));
        m_chk = m_chk + 16'(d);
        if (m_cnt != 25'h1FFFFFF) m_cnt = m_cnt + 25'd1;
        @(posedge CLK); #1;
        RD = 1'b1;
        ADDR = a;
        c0 = cyc;
        p0 = rd_pulses;
        e = '{d, m_chk, m_cnt, c0 + (mapped ? int'(L) + 2 : 2)};
        sb.push_back(e);
        @(posedge CLK); #1;
        RD = 1'b0;
        ADDR = 25'($urandom);
        check("issue_wait", 32'(WAIT), 32'h1);
        check("issue_mem_rd", 32'(MEM_RD), 32'(mapped));
        check("issue_mem_sel", 32'(MEM_SEL), 32'(sel));
        if (mapped) check("issue_mem_addr", 32'(MEM_ADDR), 32'(off));
        last_sel = MEM_SEL;
        last_addr = MEM_ADDR;
        if (dup) begin
            RD = 1'b1;
            ADDR = a ^ 25'h100;
            @(posedge CLK); #1;
            RD = 1'b0;
        end
        for (int i = 0; i < 20 && WAIT; i++) begin
            @(posedge CLK); #1;
        end
        if (WAIT) begin
            total++;
            $display("FAIL wait_timeout: got WAIT=1 after 20 cycles, required 0");
        end
        check("mem_rd_pulses", 32'(rd_pulses - p0), mapped ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s_dout;
        logic [24:0] a;
        RESET_N = 1'b0; UPLOAD = 1'b0; RD = 1'b0; ADDR = '0;
        q_mode = 0; q_fix = 8'h00; m_chk = '0; m_cnt = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset("reset");
        RESET_N = 1'b1;
        UPLOAD = 1'b1;

        // Single read of 0xA5 from region 0
        q_mode = 1; q_fix = 8'hA5;
        do_read(25'h00005, 1'b0);
        check("a5_sel", 32'(last_sel), 32'h0);
        check("a5_addr", 32'(last_addr), 32'h5);
        check("a5_dout", 32'(DOUT), 32'hA5);
        check("a5_chksum", 32'(CHKSUM), 32'h00A5);
        check("a5_byte_cnt", 32'(BYTE_CNT), 32'h1);
        q_mode = 0;

        // Region boundaries
        for (int i = 0; i < 5; i++) begin
            do_read(25'(BND_A[i]), 1'b0);
            check("bnd_sel", 32'(last_sel), 32'(BND_SEL[i]));
            if (BND_SEL[i] != 15) check("bnd_addr", 32'(last_addr), 32'(BND_OFF[i]));
            else check("bnd_unmapped_dout", 32'(DOUT), 32'hFF);
        end

        // Second RD while WAIT is high must be dropped
        do_read(25'h04123, 1'b1);
        check("dup_byte_cnt", 32'(BYTE_CNT), 32'(m_cnt));

        // Random reads across the map, including unmapped addresses
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) a = 25'($urandom);
            else a = 25'($urandom_range(0, 32'h5A000));
            do_read(a, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end

        // UPLOAD dropped the cycle after RD aborts the read
        s_dout = DOUT;
        @(posedge CLK); #1;
        RD = 1'b1; ADDR = 25'h00100;
        @(posedge CLK); #1;
        RD = 1'b0; UPLOAD = 1'b0;
        @(posedge CLK); #1;
        check("abort_done", 32'(DONE), 32'h1);
        check("abort_wait", 32'(WAIT), 32'h0);
        check("abort_mem_sel", 32'(MEM_SEL), 32'hF);
        check("abort_dout", 32'(DOUT), 32'(s_dout));
        check("abort_chksum", 32'(CHKSUM), 32'(m_chk));
        check("abort_byte_cnt", 32'(BYTE_CNT), 32'(m_cnt));
        @(posedge CLK); #1;
        check("abort_done_pulse", 32'(DONE), 32'h0);
        check("abort_chksum_hold", 32'(CHKSUM), 32'(m_chk));
        check("abort_dout_hold", 32'(DOUT), 32'(s_dout));
        UPLOAD = 1'b1;
        @(posedge CLK); #1;
        check("rise_chksum", 32'(CHKSUM), 32'h0);
        check("rise_byte_cnt", 32'(BYTE_CNT), 32'h0);
        m_chk = '0; m_cnt = '0;

        // 300 reads of 0xFF exercise checksum wrap
        q_mode = 1; q_fix = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            do_read(25'($urandom_range(0, 32'h582FF)), 1'b0);
        end
        check("ff300_chksum", 32'(CHKSUM), 32'h2AD4);
        check("ff300_byte_cnt", 32'(BYTE_CNT), 32'd300);
        q_mode = 0;

        // Asynchronous reset while the read is in its latency wait
        @(posedge CLK); #1;
        RD = 1'b1; ADDR = 25'h20000;
        @(posedge CLK); #1;
        RD = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check_reset("midread_reset");
        m_chk = '0; m_cnt = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        do_read(25'h12345, 1'b0);
        check("post_reset_byte_cnt", 32'(BYTE_CNT), 32'h1);
        check("post_reset_chksum", 32'(CHKSUM), 32'(m_chk));

        repeat (4) @(posedge CLK);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
